root_restoring_param: RTL and testbench
=======================================

ROOT_RESTORING_PARAM -- requirements
Module: root_restoring_param

Interface
REQ-001 The block SHALL use one clock, `clk`; reset, `reset`, SHALL be synchronous and active-high.
REQ-002 Parameter `WIDTH`, default 32: radicand width; SHALL be even and at least 4.
REQ-003 Parameter `STEPS`, default 1: restoring steps per clock; SHALL be 1, 2 or 4 and SHALL divide WIDTH/2.
REQ-004 Derived constants: N = WIDTH/(2*STEPS) compute cycles; CW = max(1, clog2(N)).
REQ-005 Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: block can accept an operand.
- `d` in WIDTH: unsigned radicand.
- `round_en` in 1: round-to-nearest select, sampled with `d`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `q` out WIDTH/2: root.
- `r` out WIDTH/2+1: remainder.
- `sat` out 1: rounded root saturated.
- `busy` out 1: computation in progress.
- `count` out CW: iteration index.

Function
REQ-006 The block SHALL have states IDLE, CALC and DONE.
REQ-007 An operand SHALL be accepted on the edge where `in_valid` and `in_ready` are both high; `d` and `round_en` SHALL be latched on that edge.
REQ-008 On acceptance the block SHALL clear the partial root and the partial remainder, clear `count`, and enter CALC.
REQ-009 `in_ready` SHALL be high in IDLE, and in DONE while `out_ready` is high; otherwise it SHALL be low (combinational).
REQ-010 Each restoring step SHALL perform, in order:
- rem = {rem, next two MSBs of d};
- trial = {root, 2'b01};
- if rem >= trial: rem = rem - trial and append 1 to root;
- else append 0 to root.
REQ-011 The internal remainder SHALL be WIDTH/2+2 bits wide; no step SHALL overflow it.
REQ-012 Each CALC edge SHALL chain exactly STEPS steps and increment `count`.
REQ-013 On the CALC edge where `count` == N-1, the block SHALL enter DONE and set `out_valid`.
REQ-014 `out_valid` SHALL rise exactly N edges after the accept edge (16 edges for WIDTH=32, STEPS=1).
REQ-015 `busy` SHALL equal (state == CALC).
REQ-016 The final result SHALL satisfy q*q + r == d and r <= 2q; `r` SHALL always be the unrounded remainder.
REQ-017 When the latched `round_en` is 1 and r > q, `q` SHALL be the root plus 1.
REQ-018 If that increment would exceed 2^(WIDTH/2)-1, `q` SHALL hold all-ones and `sat` SHALL be 1.
REQ-019 In all other cases `sat` SHALL be 0.
REQ-020 `q`, `r` and `sat` SHALL be stable in DONE until handshaken.
REQ-021 On an `out_valid` & `out_ready` edge the block SHALL return to IDLE.
REQ-022 If a new operand is accepted on that same edge, the block SHALL go directly to CALC and SHALL NOT pass through IDLE.
REQ-023 `in_valid` SHALL be ignored while in CALC; `d` and `round_en` changes after acceptance SHALL have no effect.
REQ-024 d = 0 SHALL yield q = 0, r = 0, sat = 0 after the normal latency.

Reset
REQ-025 While `reset` is high at an edge, the block SHALL force state IDLE.
REQ-026 Reset SHALL set `out_valid`, `busy`, `sat`, `q`, `r` and `count` to 0; `in_ready` SHALL be high once reset is released.
REQ-027 Reset asserted in CALC or DONE SHALL abort the operation with no `out_valid` pulse.
REQ-028 Reset SHALL take priority over a simultaneous handshake.

Structure
REQ-029 Package `root_pkg` SHALL hold the state enum and the N/CW derivation functions.
REQ-030 Sub-module `root_step` SHALL be combinational: one restoring step (rem, root, 2 radicand bits in; rem', root' out).
REQ-031 `root_step` SHALL be instantiated STEPS times in a chain.
REQ-032 Result rounding and saturation SHALL be registered on the final CALC edge; no comparator SHALL sit on the output path.

Verification (WIDTH=32 unless stated)
REQ-033 d=127, round_en=0, STEPS=1 -> q=11, r=6, out_valid exactly 16 edges after accept.
REQ-034 d=196 (q=14, r=0) and d=227 (q=15, r=2), STEPS=2 -> out_valid 8 edges after accept.
REQ-035 round_en=1, STEPS=4: d=240 -> q=15, r=15; d=241 -> q=16, r=16; both sat=0.
REQ-036 d=32'hFFFFFFFF with round_en=0 -> q=65535, r=131070; with round_en=1 -> q=65535, sat=1.
REQ-037 Back-to-back: in_valid held high and out_ready high -> second accept on the first result's handshake edge, no idle cycle; d=0 -> q=0, r=0.
REQ-038 Reset pulsed at count=5 -> no out_valid; next operand d=127 -> correct result at full latency.

Source files
------------

// File: rtl/root_pkg.sv
`default_nettype none
// ============================================================================
// Module      : root_pkg
// Description : Shared state encoding and size-derivation helpers for the
//               restoring square-root engine.
// Revision    : 1.0 - initial release
// ============================================================================
package root_pkg;

    // Engine sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of compute cycles for a radicand width and steps-per-clock
    function automatic int calc_n(input int width, input int steps);
        return width / (2 * steps);
    endfunction

    // Width of the iteration counter; never narrower than one bit
    function automatic int calc_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : root_pkg
`default_nettype wire

// File: rtl/root_step.sv
`default_nettype none
// ============================================================================
// Module      : root_step
// Description : One combinational restoring square-root step. Brings in the
//               next two radicand bits, tries subtracting {root, 01} and
//               appends the resulting root bit.
// Revision    : 1.0 - initial release
// ============================================================================
module root_step #(
    parameter int HW = 16                  // root width
) (
    input  logic [HW+1:0] i_rem,           // partial remainder
    input  logic [HW-1:0] i_root,          // partial root
    input  logic [1:0]    i_bits,          // next two radicand MSBs
    output logic [HW+1:0] o_rem,
    output logic [HW-1:0] o_root
);

    logic [HW+1:0] w_shift;
    logic [HW+1:0] w_trial;
    logic          w_ge;
    logic [1:0]    w_unused_rem_hi;

    // Remainder never exceeds 2*root, so before the shift it fits in HW
    // bits and its top two bits are always zero here.
    assign w_unused_rem_hi = i_rem[HW+1:HW];

    assign w_shift = {i_rem[HW-1:0], i_bits};
    assign w_trial = {i_root, 2'b01};
    assign w_ge    = (w_shift >= w_trial);
    assign o_rem   = w_ge ? (w_shift - w_trial) : w_shift;
    // The root MSB is still zero until the final step, so dropping it is safe
    assign o_root  = {i_root[HW-2:0], w_ge};

endmodule : root_step
`default_nettype wire

// File: rtl/root_restoring_param.sv
`default_nettype none
// ============================================================================
// Module      : root_restoring_param
// Description : Iterative restoring integer square root with a valid/ready
//               handshake, STEPS restoring steps per clock and optional
//               round-to-nearest with saturation of the root.
// Revision    : 1.0 - initial release
// ============================================================================
module root_restoring_param
    import root_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      d,
    input  logic                  round_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH/2-1:0]    q,
    output logic [WIDTH/2:0]      r,
    output logic                  sat,
    output logic                  busy,
    output logic [calc_cw(calc_n(WIDTH, STEPS))-1:0] count
);

    localparam int c_HW = WIDTH / 2;
    localparam int c_RW = c_HW + 2;
    localparam int c_N  = calc_n(WIDTH, STEPS);
    localparam int c_CW = calc_cw(c_N);

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_N - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_HW-1:0] c_ROOT_ONE = c_HW'(1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_rad;
    logic                r_round;
    logic [c_RW-1:0]     r_rem;
    logic [c_HW-1:0]     r_root;
    logic [c_CW-1:0]     r_count;
    logic [c_HW-1:0]     r_q;
    logic [c_HW:0]       r_r;
    logic                r_sat;
    logic                r_out_valid;

    logic [c_RW-1:0]     w_rem  [STEPS+1];
    logic [c_HW-1:0]     w_root [STEPS+1];
    logic                w_accept;
    logic [c_HW-1:0]     w_fin_root;
    logic [c_HW:0]       w_fin_rem;
    logic                w_round_up;
    logic                w_root_max;
    logic [c_HW-1:0]     w_q_next;

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == CALC);
    assign q         = r_q;
    assign r         = r_r;
    assign sat       = r_sat;
    assign count     = r_count;

    // Chain of STEPS restoring steps fed from the current partial state
    assign w_rem[0]  = r_rem;
    assign w_root[0] = r_root;

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
            root_step #(
                .HW     (c_HW)
            ) u_step (
                .i_rem  (w_rem[gi]),
                .i_root (w_root[gi]),
                .i_bits (r_rad[WIDTH-1-2*gi -: 2]),
                .o_rem  (w_rem[gi+1]),
                .o_root (w_root[gi+1])
            );
        end
    endgenerate

    // Rounding decision is taken on the final compute edge and registered
    assign w_fin_root = w_root[STEPS];
    assign w_fin_rem  = w_rem[STEPS][c_HW:0];
    assign w_round_up = r_round && (w_fin_rem > {1'b0, w_fin_root});
    assign w_root_max = &w_fin_root;
    assign w_q_next   = !w_round_up ? w_fin_root :
                        (w_root_max ? {c_HW{1'b1}} : (w_fin_root + c_ROOT_ONE));

    // Sequencer: accept operand, iterate, hold result until handshaken
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rad       <= '0;
            r_round     <= 1'b0;
            r_rem       <= '0;
            r_root      <= '0;
            r_count     <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rad   <= d;
                        r_round <= round_en;
                        r_rem   <= '0;
                        r_root  <= '0;
                        r_count <= '0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_rem   <= w_rem[STEPS];
                    r_root  <= w_fin_root;
                    r_rad   <= r_rad << (2 * STEPS);
                    r_count <= r_count + c_CNT_ONE;
                    if (r_count == c_CNT_LAST) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_q         <= w_q_next;
                        r_r         <= w_fin_rem;
                        r_sat       <= w_round_up && w_root_max;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_accept) begin
                            r_rad   <= d;
                            r_round <= round_en;
                            r_rem   <= '0;
                            r_root  <= '0;
                            r_count <= '0;
                            r_state <= CALC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : root_restoring_param
`default_nettype wire

// File: tb/tb_root_restoring_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_root_restoring_param
// Description : Self-checking bench; three engines (1, 2 and 4 steps per
//               clock) with a scoreboard of independently modelled results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_root_restoring_param;
    import root_pkg::*;

    typedef struct {
        logic [15:0] q;
        logic [16:0] r;
        logic        sat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] d         [3];
    logic        round_en  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] q         [3];
    logic [16:0] r         [3];
    logic        sat       [3];
    logic        busy      [3];
    logic [3:0]  cnt       [3];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int ST  = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
            localparam int CWG = calc_cw(calc_n(32, ST));
            logic [CWG-1:0] w_cnt;
            root_restoring_param #(
                .WIDTH     (32),
                .STEPS     (ST)
            ) u_dut (
                .clk       (clk),
                .reset     (rst),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .d         (d[gi]),
                .round_en  (round_en[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .q         (q[gi]),
                .r         (r[gi]),
                .sat       (sat[gi]),
                .busy      (busy[gi]),
                .count     (w_cnt)
            );
            assign cnt[gi] = 4'(w_cnt);
        end
    endgenerate

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: greedy bit-by-bit search on squares
    function automatic exp_t model(input logic [31:0] dv, input logic rnd);
        exp_t        e;
        longint      root;
        longint      t;
        longint      rem;
        root = 0;
        for (int b = 15; b >= 0; b--) begin
            t = root | (64'd1 << b);
            if (t * t <= longint'(dv)) root = t;
        end
        rem   = longint'(dv) - root * root;
        e.sat = 1'b0;
        if (rnd && rem > root) begin
            if (root == 65535) e.sat = 1'b1;
            else               root = root + 1;
        end
        e.q = 16'(root);
        e.r = 17'(rem);
        return e;
    endfunction

    function automatic int lat_of(input int idx);
        return 16 >> idx;
    endfunction

    // Pop the oldest expectation and compare it against the DUT outputs
    task automatic compare_result(input int idx, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_val({tag, "_q"},   64'(q[idx]),   64'(e.q));
            check_val({tag, "_r"},   64'(r[idx]),   64'(e.r));
            check_val({tag, "_sat"}, 64'(sat[idx]), 64'(e.sat));
        end
    endtask

    task automatic wait_valid(input int idx, output int lat);
        lat = 0;
        while (!out_valid[idx] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input int idx, input logic [31:0] dv, input logic rnd,
                          input int hold, input string tag);
        int lat;
        int k;
        sb.push_back(model(dv, rnd));
        @(posedge clk); #1;
        in_valid[idx] = 1'b1;
        d[idx]        = dv;
        round_en[idx] = rnd;
        k = 0;
        while (!in_ready[idx] && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        d[idx]        = $urandom;
        round_en[idx] = ~rnd;
        check_val({tag, "_busy"}, 64'(busy[idx]), 64'd1);
        wait_valid(idx, lat);
        check_val({tag, "_lat"}, 64'(lat), 64'(lat_of(idx)));
        if (hold > 0) begin
            out_ready[idx] = 1'b0;
            repeat (hold) @(posedge clk);
            #1;
            check_val({tag, "_hold_valid"}, 64'(out_valid[idx]), 64'd1);
            out_ready[idx] = 1'b1;
        end
        compare_result(idx, tag);
    endtask

    initial begin
        int   lat;
        int   k;
        logic seen;
        exp_t e;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            d[i]         = '0;
            round_en[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check_val("rst_in_ready",  64'(in_ready[0]),  64'd1);
        check_val("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_val("rst_busy",      64'(busy[0]),      64'd0);
        check_val("rst_q",         64'(q[0]),         64'd0);
        check_val("rst_r",         64'(r[0]),         64'd0);
        check_val("rst_sat",       64'(sat[0]),       64'd0);
        check_val("rst_count",     64'(cnt[0]),       64'd0);

        run_op(0, 32'd127,        1'b0, 0, "s1_127");
        run_op(0, 32'hFFFFFFFF,   1'b0, 0, "s1_max");
        run_op(0, 32'hFFFFFFFF,   1'b1, 0, "s1_max_rnd");
        run_op(0, 32'd0,          1'b1, 0, "s1_zero");
        run_op(1, 32'd196,        1'b0, 3, "s2_196");
        run_op(1, 32'd227,        1'b0, 0, "s2_227");
        run_op(2, 32'd240,        1'b1, 0, "s4_240");
        run_op(2, 32'd241,        1'b1, 0, "s4_241");
        for (int i = 0; i < 4; i++)
            run_op(2, $urandom, 1'($urandom_range(0, 1)), 0, "s4_rand");

        // Back-to-back: second operand accepted on the first handshake edge
        sb.push_back(model(32'd127, 1'b0));
        sb.push_back(model(32'd0, 1'b0));
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        d[0]        = 32'd127;
        round_en[0] = 1'b0;
        @(posedge clk); #1;
        d[0] = 32'd0;
        wait_valid(0, lat);
        check_val("b2b_lat1", 64'(lat), 64'd16);
        compare_result(0, "b2b_first");
        check_val("b2b_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check_val("b2b_nogap_busy",  64'(busy[0]),      64'd1);
        check_val("b2b_nogap_valid", 64'(out_valid[0]), 64'd0);
        check_val("b2b_nogap_count", 64'(cnt[0]),       64'd0);
        wait_valid(0, lat);
        check_val("b2b_lat2", 64'(lat), 64'd16);
        compare_result(0, "b2b_second");

        // Reset pulsed mid-computation aborts without a result
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        d[0]        = 32'd500;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        k = 0;
        while (cnt[0] != 4'd5 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("abort_reach_count", 64'(cnt[0]), 64'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("abort_busy",  64'(busy[0]),     64'd0);
        check_val("abort_count", 64'(cnt[0]),      64'd0);
        check_val("abort_ready", 64'(in_ready[0]), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen = 1'b1;
        end
        check_val("abort_no_valid", 64'(seen), 64'd0);
        run_op(0, 32'd127, 1'b0, 0, "post_abort_127");

        // Fixed expectations straight from the worked examples
        e = model(32'd127, 1'b0);
        check_val("model_127_q", 64'(e.q), 64'd11);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule : tb_root_restoring_param
`default_nettype wire
